fpu_normalize_unit: RTL and testbench
=====================================

Name: fpu_normalize_unit

Overview:
- Multi-cycle normalizer placed directly upstream of the 80-bit extended-precision rounding unit in the FPU8087 datapath.
- Accepts a raw arithmetic result: sign, wide signed exponent, and a 68-bit mantissa with carry and guard/round/sticky bits.
- Normalizes iteratively: coarse left shifts of up to 16 bits per cycle, 1-bit right shift on carry, right shift into the denormal range on exponent underflow.
- Emits a packed 80-bit value plus GRS bits and exception flags through valid/ready handshakes.

Parameters:
- SHIFT_STEP, 16, maximum left/right shift distance per NORM cycle (power of two, 1..32)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- in_valid  in  1  input operand valid
- in_ready  out  1  block can accept an operand
- in_sign  in  1  sign of result
- in_exp  in  17  signed two's-complement biased exponent (bias 0x3FFF)
- in_mant  in  68  [67]=carry, [66]=integer bit, [65:3]=fraction, [2]=guard, [1]=round, [0]=sticky
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_value  out  80  {sign, exp[14:0], mant[63:0]}, i.e. mant = internal [66:3]
- out_grs  out  3  internal mant[2:0] for rounding
- out_zero  out  1  result is exact zero
- out_overflow  out  1  exponent ≥ 0x7FFF; out_value forced to infinity
- out_underflow  out  1  result denormal (exp field 0, mantissa nonzero)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0; out_value, out_grs and all flags =0. Reset mid-operation discards the operand; no result is produced.
- Internal registers: mant[67:0]; exp held as 18-bit signed, so +1 and -SHIFT_STEP never wrap. Upstream guarantees -0x8000 ≤ in_exp ≤ 0x7FFF.
- State IDLE:
  - in_ready=1.
  - On in_valid & in_ready, latch sign/exp/mant and go to NORM.
- State NORM: one action per cycle, first matching rule wins.
  1. mant==0 → DONE, zero result (exp field 0, grs 0, out_zero=1).
  2. mant[67]=1 → mant = mant>>1 with new[0] = old[1] | old[0]; exp+=1; stay in NORM.
  3. exp<1 → shift right by n = min(SHIFT_STEP, 1-exp); every bit shifted out is ORed into bit 0; exp+=n; stay in NORM.
  4. mant[66]=1 → DONE, normal result.
  5. Otherwise:
     - lz = leading zeros of mant[66:66-SHIFT_STEP+1], saturated to SHIFT_STEP.
     - n = min(lz, exp-1).
     - n=0 (exp==1) → DONE, denormal result.
     - Else mant<<=n (zero fill; the sticky bit shifts as data), exp-=n, stay in NORM.
- Entering DONE: register the outputs.
  - exp≥0x7FFF → out_value = {sign, 0x7FFF, 64'h0}, grs=0, out_overflow=1.
  - Denormal (exp==1 & mant[66]=0) → exp field 0, out_underflow=1.
  - Otherwise exp field = exp[14:0].
- State DONE:
  - out_valid=1 and in_ready=0.
  - Outputs hold stable until out_ready=1; that edge returns the block to IDLE with out_valid=0.
  - in_valid is ignored outside IDLE.
- Latency:
  - An already-normalized operand has out_valid high on the 2nd cycle after the acceptance edge.
  - Each extra NORM action (carry, shift) adds 1 cycle.
- Throughput: one operand per (latency + 1) cycles. No pipelining.

Test Plan:
- Normalized: exp=0x3FFF, mant=0x4_0000_0000_0000_0000 → out_value={0,0x3FFF,0x8000000000000000}, grs=000, no flags, out_valid 2 cycles after acceptance.
- Carry: exp=0x3FFF, mant=0x8_0000_0000_0000_0001 → exp 0x4000, mant 0x8000000000000000, grs=001.
- Left shift by 63: exp=0x3FFF, mant=0x0_0000_0000_0000_0008 → shift steps 16,16,16,15; out exp 0x3FC0, mant 0x8000000000000000; out_valid 6 cycles after acceptance.
- Zero and overflow:
  - mant=0, sign=1 → out_value={1,0,0}, out_zero=1.
  - exp=0x7FFE, mant=0x8_0000_0000_0000_0000 → {s,0x7FFF,0}, out_overflow=1.
- Denormal plus backpressure:
  - Stimulus: exp=0x0000, mant=0x4_0000_0000_0000_0000, out_ready=0 for 5 cycles.
  - Result: exp field 0, mant 0x4000000000000000, out_underflow=1.
  - Outputs stay stable with in_ready=0 until out_ready rises, then IDLE.
- Reset mid-NORM: assert rst_n=0 during the left-shift case → out_valid=0 and in_ready=1 immediately; no stale result after release.

Source files
------------

// File: rtl/fpu_normalize_unit.sv
// Iterative normalizer feeding the extended-precision rounding unit.
// Handles carry, coarse left shifts and denormalizing right shifts.
module fpu_normalize_unit #(
    parameter int SHIFT_STEP = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [16:0] in_exp,
    input  logic [67:0] in_mant,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [79:0] out_value,
    output logic [2:0]  out_grs,
    output logic        out_zero,
    output logic        out_overflow,
    output logic        out_underflow
);

    localparam int SW = $clog2(SHIFT_STEP) + 1;
    localparam logic signed [17:0] STEP_S = 18'(SHIFT_STEP);
    localparam logic signed [17:0] EXP_MAX = 18'sh07FFF;

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_e;

    state_e             state_q, state_d;
    logic               sign_q, sign_d;
    logic signed [17:0] exp_q, exp_d;
    logic [67:0]        mant_q, mant_d;
    logic [79:0]        value_q, value_d;
    logic [2:0]         grs_q, grs_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;

    logic [SW-1:0]      lz, ln, rn;
    logic signed [17:0] lz_s, ln_s, rn_s;
    logic signed [17:0] exp_m1, exp_r;
    logic [67:0]        rmask, rshift;

    // Leading zeros within the top SHIFT_STEP bits below the carry.
    always_comb begin
        lz = SW'(SHIFT_STEP);
        for (int i = SHIFT_STEP - 1; i >= 0; i--) begin
            if (mant_q[66-i]) lz = SW'(i);
        end
    end

    always_comb begin
        exp_m1 = exp_q - 18'sd1;
        exp_r  = 18'sd1 - exp_q;
        lz_s   = $signed({{(18-SW){1'b0}}, lz});
        ln     = (exp_m1 < lz_s) ? exp_m1[SW-1:0] : lz;
        rn     = (exp_r > STEP_S) ? SW'(SHIFT_STEP) : exp_r[SW-1:0];
        ln_s   = $signed({{(18-SW){1'b0}}, ln});
        rn_s   = $signed({{(18-SW){1'b0}}, rn});
        rmask  = (68'd1 << rn) - 68'd1;
        rshift = mant_q >> rn;
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        value_d = value_q;
        grs_d   = grs_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    exp_d   = {in_exp[16], in_exp};
                    mant_d  = in_mant;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (mant_q == 68'd0) begin
                    value_d = {sign_q, 79'h0};
                    grs_d   = 3'b000;
                    {zero_d, ovf_d, unf_d} = 3'b100;
                    state_d = DONE;
                end else if (mant_q[67]) begin
                    mant_d = {1'b0, mant_q[67:2], mant_q[1] | mant_q[0]};
                    exp_d  = exp_q + 18'sd1;
                end else if (exp_q < 18'sd1) begin
                    mant_d = {rshift[67:1], rshift[0] | (|(mant_q & rmask))};
                    exp_d  = exp_q + rn_s;
                end else if (mant_q[66]) begin
                    state_d = DONE;
                    if (exp_q >= EXP_MAX) begin
                        value_d = {sign_q, 15'h7FFF, 64'h0};
                        grs_d   = 3'b000;
                        {zero_d, ovf_d, unf_d} = 3'b010;
                    end else begin
                        value_d = {sign_q, exp_q[14:0], mant_q[66:3]};
                        grs_d   = mant_q[2:0];
                        {zero_d, ovf_d, unf_d} = 3'b000;
                    end
                end else if (ln == '0) begin
                    value_d = {sign_q, 15'h0, mant_q[66:3]};
                    grs_d   = mant_q[2:0];
                    {zero_d, ovf_d, unf_d} = 3'b001;
                    state_d = DONE;
                end else begin
                    mant_d = mant_q << ln;
                    exp_d  = exp_q - ln_s;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            mant_q  <= '0;
            value_q <= '0;
            grs_q   <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            value_q <= value_d;
            grs_q   <= grs_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = (state_q == DONE);
    assign out_value     = value_q;
    assign out_grs       = grs_q;
    assign out_zero      = zero_q;
    assign out_overflow  = ovf_q;
    assign out_underflow = unf_q;

endmodule

// File: tb/tb_fpu_normalize_unit.sv
// Bench for fpu_normalize_unit: directed vectors, reference model,
// per-cycle output compare and hand-computed anchor values.
module tb_fpu_normalize_unit;

    localparam int STEP = 16;

    typedef struct packed {
        logic [79:0] value;
        logic [2:0]  grs;
        logic [2:0]  flags;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [16:0] in_exp = '0;
    logic [67:0] in_mant = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [79:0] out_value;
    logic [2:0]  out_grs;
    logic        out_zero;
    logic        out_overflow;
    logic        out_underflow;

    int errors = 0;
    int checks = 0;
    res_t expq[$];

    fpu_normalize_unit #(.SHIFT_STEP(STEP)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_sign(in_sign),
        .in_exp(in_exp),
        .in_mant(in_mant),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_value(out_value),
        .out_grs(out_grs),
        .out_zero(out_zero),
        .out_overflow(out_overflow),
        .out_underflow(out_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] got,
                       input logic [79:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Result of normalizing the value m * 2^(e-bias) to the 80-bit format,
    // plus the number of NORM cycles the iterative unit should spend.
    function automatic void model(input logic s, input int e,
                                  input logic [67:0] m,
                                  output res_t r, output int cyc);
        logic [67:0] mm;
        int ee, lz, sh, rr;
        logic lost;
        mm = m;
        ee = e;
        cyc = 1;
        r = '0;
        if (mm == 68'd0) begin
            r.value = {s, 79'h0};
            r.flags = 3'b100;
            return;
        end
        if (mm[67]) begin
            mm = {1'b0, mm[67:2], mm[1] | mm[0]};
            ee++;
            cyc++;
        end
        if (ee < 1) begin
            rr = 1 - ee;
            lost = 1'b0;
            for (int k = 0; k < rr; k++) begin
                lost = lost | mm[0];
                mm = mm >> 1;
            end
            mm[0] = mm[0] | lost;
            ee = 1;
            cyc += (rr + STEP - 1) / STEP;
        end else begin
            lz = 0;
            while (lz < 67 && !mm[66-lz]) lz++;
            sh = (lz < ee - 1) ? lz : ee - 1;
            mm = mm << sh;
            ee -= sh;
            cyc += (sh + STEP - 1) / STEP;
        end
        if (ee >= 'h7FFF) begin
            r.value = {s, 15'h7FFF, 64'h0};
            r.flags = 3'b010;
        end else if (!mm[66]) begin
            r.value = {s, 15'h0, mm[66:3]};
            r.grs = mm[2:0];
            r.flags = 3'b001;
        end else begin
            r.value = {s, ee[14:0], mm[66:3]};
            r.grs = mm[2:0];
        end
    endfunction

    // Checks the output bundle against the expected head on every valid cycle.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (expq.size() == 0) begin
                chk("unexpected_valid", 80'(out_valid), 80'h0);
            end else begin
                chk("value", out_value, expq[0].value);
                chk("grs", 80'(out_grs), 80'(expq[0].grs));
                chk("flags", 80'({out_zero, out_overflow, out_underflow}),
                    80'(expq[0].flags));
                chk("busy_in_ready", 80'(in_ready), 80'h0);
                if (out_ready) void'(expq.pop_front());
            end
        end
    end

    task automatic send(input logic s, input int e, input logic [67:0] m,
                        input int hold, input logic has_lit,
                        input logic [79:0] lv, input logic [2:0] lg,
                        input logic [2:0] lf, input int lcyc);
        res_t r;
        int ncyc, lat;
        model(s, e, m, r, ncyc);
        expq.push_back(r);
        @(posedge clk);
        #1;
        chk("idle_ready", 80'(in_ready), 80'h1);
        in_sign = s;
        in_exp = e[16:0];
        in_mant = m;
        in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 80'(lat), 80'(ncyc));
        if (has_lit) begin
            chk("lit_value", out_value, lv);
            chk("lit_grs", 80'(out_grs), 80'(lg));
            chk("lit_flags", 80'({out_zero, out_overflow, out_underflow}),
                80'(lf));
            chk("lit_cycle", 80'(lat + 1), 80'(lcyc));
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 80'(out_valid), 80'h1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ret_valid", 80'(out_valid), 80'h0);
        chk("ret_ready", 80'(in_ready), 80'h1);
    endtask

    initial begin
        #1;
        chk("rst_valid", 80'(out_valid), 80'h0);
        chk("rst_ready", 80'(in_ready), 80'h1);
        chk("rst_value", out_value, 80'h0);
        chk("rst_misc", 80'({out_grs, out_zero, out_overflow, out_underflow}),
            80'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        send(0, 'h3FFF, 68'h4_0000_0000_0000_0000, 0, 1,
             {1'b0, 15'h3FFF, 64'h8000_0000_0000_0000}, 3'b000, 3'b000, 2);
        send(0, 'h3FFF, 68'h8_0000_0000_0000_0001, 0, 1,
             {1'b0, 15'h4000, 64'h8000_0000_0000_0000}, 3'b001, 3'b000, 3);
        send(0, 'h3FFF, 68'h0_0000_0000_0000_0008, 0, 1,
             {1'b0, 15'h3FC0, 64'h8000_0000_0000_0000}, 3'b000, 3'b000, 6);
        send(1, 'h1234, 68'h0, 0, 1,
             {1'b1, 79'h0}, 3'b000, 3'b100, 2);
        send(0, 'h7FFE, 68'h8_0000_0000_0000_0000, 0, 1,
             {1'b0, 15'h7FFF, 64'h0}, 3'b000, 3'b010, 3);
        send(0, 0, 68'h4_0000_0000_0000_0000, 5, 1,
             {1'b0, 15'h0000, 64'h4000_0000_0000_0000}, 3'b000, 3'b001, 3);

        send(0, -40, 68'h4_0000_0000_0000_0123, 0, 0, '0, '0, '0, 0);
        send(1, 5, 68'h0_0004_0000_0000_0000, 0, 0, '0, '0, '0, 0);
        send(0, 1, 68'h1_2345_6789_ABCD_EF01, 0, 0, '0, '0, '0, 0);
        send(0, 'h20, 68'h0_0000_0000_0000_0007, 2, 0, '0, '0, '0, 0);
        send(1, -3, 68'h8_0000_0000_0000_000F, 0, 0, '0, '0, '0, 0);
        send(0, 'h7FFF, 68'h4_0000_0000_0000_0005, 0, 0, '0, '0, '0, 0);
        send(1, 'h4000, 68'h2_F00D_0000_BEEF_0006, 1, 0, '0, '0, '0, 0);

        @(posedge clk);
        #1;
        in_sign = 1'b0;
        in_exp = 17'h3FFF;
        in_mant = 68'h0_0000_0000_0000_0008;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 80'(out_valid), 80'h0);
        chk("midrst_ready", 80'(in_ready), 80'h1);
        expq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            chk("no_stale", 80'(out_valid), 80'h0);
        end
        send(0, 'h3FFF, 68'h0_0000_0000_0000_0008, 0, 1,
             {1'b0, 15'h3FC0, 64'h8000_0000_0000_0000}, 3'b000, 3'b000, 6);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
